// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path: receiver FSM encoding and channel tags.
package i2s_pkg;

   typedef enum logic [1:0] {SYNC, DELAY, SHIFT, SKIP} i2s_rx_state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/sd_synchronizer.sv
// Two-flop synchroniser bringing the asynchronous mic data pin into the clk_in domain.
module sd_synchronizer (
   input  logic clk_in,
   input  logic rst_in,
   input  logic sd_async,
   output logic sd_sync
);

   logic sd_meta;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sd_meta <= 1'b0;
         sd_sync <= 1'b0;
      end else begin
         sd_meta <= sd_async;
         sd_sync <= sd_meta;
      end
   end

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserialiser: one signed PCM word per ws slot, tagged with its channel, on a valid/ready port.
//
// state | meaning
// SYNC  | after reset, waiting for the first ws edge to find a slot boundary
// DELAY | slot started, discarding the one-bit I2S delay bit
// SHIFT | capturing SAMPLE_WIDTH data bits, MSB first
// SKIP  | word captured, ignoring the slot padding until the next ws edge
module i2s_receiver
   import i2s_pkg::*;
#(
   parameter int OVER_SAMPLING_RATE = 64,
   parameter int SAMPLE_WIDTH       = 24
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    sck_in,
   input  logic                    ws_in,
   input  logic                    sd_in,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic                    sample_channel_out,
   output logic                    sample_valid_out,
   input  logic                    sample_ready_in,
   output logic                    overrun_out,
   output logic                    frame_err_out
);

   localparam int SLOT_BITS = OVER_SAMPLING_RATE / 2;
   localparam int CNT_W     = $clog2(SLOT_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

   i2s_rx_state_t           state;
   logic                    sd_sync;
   logic                    sck_q;
   logic                    ws_q;
   logic                    rise;
   logic                    ws_edge;
   logic [CNT_W-1:0]        bit_cnt;
   logic [SAMPLE_WIDTH-2:0] shift_reg;
   logic [SAMPLE_WIDTH-1:0] word_next;
   logic                    slot_ch;
   logic                    word_done;
   logic                    take;

   sd_synchronizer u_sd_sync (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .sd_async (sd_in),
      .sd_sync  (sd_sync)
   );

   assign rise      = sck_in & ~sck_q;
   assign ws_edge   = ws_in ^ ws_q;
   assign word_next = {shift_reg, sd_sync};
   assign take      = sample_valid_out & sample_ready_in;

   // A ws edge overrides a coincident rise, so the last bit can never complete a word then.
   assign word_done = (state == SHIFT) && !ws_edge && rise && (bit_cnt == LAST_BIT);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sck_q         <= 1'b0;
         ws_q          <= 1'b0;
         state         <= SYNC;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         slot_ch       <= CH_LEFT;
         frame_err_out <= 1'b0;
      end else begin
         sck_q <= sck_in;
         ws_q  <= ws_in;
         if (ws_edge) begin
            slot_ch <= ws_in;
            state   <= DELAY;
            bit_cnt <= '0;
            if (state == DELAY || state == SHIFT)
               frame_err_out <= 1'b1;
         end else if (rise) begin
            case (state)
               DELAY: begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
               SHIFT: begin
                  shift_reg <= word_next[SAMPLE_WIDTH-2:0];
                  if (bit_cnt == LAST_BIT)
                     state <= SKIP;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Single holding register: a finished word is lost rather than overwrite an unconsumed one.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sample_out         <= '0;
         sample_channel_out <= 1'b0;
         sample_valid_out   <= 1'b0;
         overrun_out        <= 1'b0;
      end else if (word_done) begin
         if (!sample_valid_out || take) begin
            sample_out         <= word_next;
            sample_channel_out <= slot_ch;
            sample_valid_out   <= 1'b1;
         end else begin
            overrun_out <= 1'b1;
         end
      end else if (take) begin
         sample_valid_out <= 1'b0;
      end
   end

endmodule
